// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared types and constants for the nibble-serial adder
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  // Nibble counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return ((width / NIB_W) > 1) ? $clog2(width / NIB_W) : 1;
  endfunction

endpackage

// File: rtl/lca_4.sv
// rtl/lca_4.sv - 4-bit carry-lookahead adder slice
module lca_4 (
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic       C_1,
  output logic [3:0] S,
  output logic       CO
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A_in ^ B_in;
  assign g = A_in & B_in;

  // Carries are flattened from generate/propagate so no ripple chain exists.
  assign c[0] = C_1;
  assign c[1] = g[0] | (p[0] & C_1);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_1);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C_1);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & C_1);

  assign S  = p ^ c[3:0];
  assign CO = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - add/subtract engine reusing one 4-bit slice per nibble
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  import nsa_pkg::*;

  localparam int N     = WIDTH / NIB_W;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(N - 1);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NIB_W-1:0] nib_s;
  logic             nib_co;

  lca_4 u_slice (
    .A_in (a_q[NIB_W-1:0]),
    .B_in (b_q[NIB_W-1:0]),
    .C_1  (c_q),
    .S    (nib_s),
    .CO   (nib_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          c_d     = in_sub | in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d = {nib_s, sum_q[WIDTH-1:NIB_W]};
        a_d   = {{NIB_W{1'b0}}, a_q[WIDTH-1:NIB_W]};
        b_d   = {{NIB_W{1'b0}}, b_q[WIDTH-1:NIB_W]};
        c_d   = nib_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_NIB) begin
          // The top nibble is in the slice now, so its bit 3 holds the operand sign bits.
          cout_d  = nib_co;
          ovf_d   = (a_q[NIB_W-1] ~^ b_q[NIB_W-1]) & (nib_s[NIB_W-1] ^ a_q[NIB_W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
